// File: rtl/uart_pkg.sv
// Shared encodings, state type and timing helpers
// for the uart block and its FIFO.
package uart_pkg;

   localparam int CHECK_NONE = 0;
   localparam int CHECK_ODD  = 1;
   localparam int CHECK_EVEN = 2;

   localparam int STOP_ONE = 0;
   localparam int STOP_TWO = 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int frame_len(input int bits, input int chk,
                                    input int stp);
      return 1 + bits + ((chk != CHECK_NONE) ? 1 : 0)
             + ((stp == STOP_TWO) ? 2 : 1);
   endfunction

   localparam int FRAME_LEN_DEFAULT = frame_len(8, CHECK_ODD, STOP_ONE);

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on rdata
// whenever the FIFO is non-empty and reads as zero otherwise.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers are exactly AW bits wide, so they wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart.sv
// Full-duplex UART: FIFO-buffered transmitter and receiver
// with configurable payload width, parity and stop bits.
module uart
   import uart_pkg::*;
#(
   parameter int system_clk  = 50000000,
   parameter int band_rate   = 115200,
   parameter int data_bits   = 8,
   parameter int check_mode  = 1,
   parameter int stop_mode   = 0,
   parameter int fifo_deepth = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_en,
   input  logic [data_bits-1:0] data_in,
   input  logic                 data_in_valid,
   output logic                 data_in_ready,
   output logic                 tx,
   input  logic                 rx_en,
   input  logic                 rx,
   output logic [data_bits-1:0] data_out,
   output logic                 data_out_valid,
   input  logic                 data_out_ready,
   output logic                 check_flag
);

   localparam int DIV = calc_div(system_clk, band_rate);
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
   localparam logic [2:0]    LAST_BIT = 3'(data_bits - 1);
   localparam bit HAS_PAR  = (check_mode != CHECK_NONE);
   localparam bit ODD_PAR  = (check_mode == CHECK_ODD);
   localparam bit TWO_STOP = (stop_mode == STOP_TWO);

   logic                 tx_full;
   logic                 tx_empty;
   logic                 tx_load;
   logic                 tx_tick;
   logic                 tx_last_stop;
   logic [data_bits-1:0] tx_head;
   logic [data_bits-1:0] tx_shift;
   logic [CW-1:0]        tx_cnt;
   logic [2:0]           tx_bit;
   logic                 tx_par;
   logic                 tx_stop2;
   uart_state_e          tx_state;

   assign data_in_ready = rst_n && !tx_full;
   assign tx_tick       = (tx_cnt == BIT_END);
   assign tx_last_stop  = (tx_state == STOP) && tx_tick
                          && (!TWO_STOP || tx_stop2);
   // Reloading straight from STOP keeps back-to-back frames gapless.
   assign tx_load = tx_en && !tx_empty
                    && ((tx_state == IDLE) || tx_last_stop);

   uart_fifo #(
      .WIDTH(data_bits),
      .DEPTH(fifo_deepth)
   ) u_tx_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (data_in_valid && data_in_ready),
      .wdata(data_in),
      .pop  (tx_load),
      .rdata(tx_head),
      .full (tx_full),
      .empty(tx_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= IDLE;
         tx       <= 1'b1;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
         tx_stop2 <= 1'b0;
      end else if (tx_load) begin
         tx_state <= START;
         tx       <= 1'b0;
         tx_cnt   <= '0;
         tx_shift <= tx_head;
         tx_par   <= (^tx_head) ^ ODD_PAR;
      end else begin
         tx_cnt <= (tx_state == IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
         if (tx_tick) begin
            unique case (tx_state)
               START: begin
                  tx_state <= DATA;
                  tx       <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= '0;
               end
               DATA: begin
                  if (tx_bit == LAST_BIT) begin
                     if (HAS_PAR) begin
                        tx_state <= PARITY;
                        tx       <= tx_par;
                     end else begin
                        tx_state <= STOP;
                        tx       <= 1'b1;
                        tx_stop2 <= 1'b0;
                     end
                  end else begin
                     tx       <= tx_shift[0];
                     tx_shift <= tx_shift >> 1;
                     tx_bit   <= tx_bit + 1'b1;
                  end
               end
               PARITY: begin
                  tx_state <= STOP;
                  tx       <= 1'b1;
                  tx_stop2 <= 1'b0;
               end
               STOP: begin
                  if (tx_last_stop) tx_state <= IDLE;
                  else              tx_stop2 <= 1'b1;
               end
               default: tx_state <= IDLE;
            endcase
         end
      end
   end

   logic                 rx_s1;
   logic                 rx_s2;
   logic                 rx_prev;
   logic                 rx_tick;
   logic                 rx_half;
   logic                 rx_bad;
   logic                 rx_wr;
   logic                 rx_full;
   logic                 rx_empty;
   logic                 rx_par;
   logic [data_bits-1:0] rx_shift;
   logic [CW-1:0]        rx_cnt;
   logic [2:0]           rx_bit;
   uart_state_e          rx_state;

   assign rx_tick = (rx_cnt == BIT_END);
   assign rx_half = (rx_cnt == HALF_END);
   assign rx_bad  = HAS_PAR && ((^rx_shift) ^ rx_par ^ ODD_PAR);
   assign rx_wr   = rx_en && (rx_state == STOP) && rx_tick
                    && rx_s2 && !rx_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state   <= IDLE;
         rx_cnt     <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_par     <= 1'b0;
         check_flag <= 1'b0;
      end else begin
         check_flag <= 1'b0;
         if (!rx_en) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
         end else begin
            rx_cnt <= (rx_state == IDLE || rx_tick
                       || (rx_state == START && rx_half))
                      ? '0 : rx_cnt + 1'b1;
            unique case (rx_state)
               IDLE: begin
                  if (rx_prev && !rx_s2) rx_state <= START;
               end
               START: begin
                  if (rx_half) begin
                     rx_state <= rx_s2 ? IDLE : DATA;
                     rx_bit   <= '0;
                  end
               end
               DATA: begin
                  if (rx_tick) begin
                     rx_shift <= {rx_s2, rx_shift[data_bits-1:1]};
                     rx_bit   <= rx_bit + 1'b1;
                     if (rx_bit == LAST_BIT)
                        rx_state <= HAS_PAR ? PARITY : STOP;
                  end
               end
               PARITY: begin
                  if (rx_tick) begin
                     rx_par   <= rx_s2;
                     rx_state <= STOP;
                  end
               end
               STOP: begin
                  if (rx_tick) begin
                     check_flag <= rx_bad;
                     rx_state   <= IDLE;
                  end
               end
               default: rx_state <= IDLE;
            endcase
         end
      end
   end

   uart_fifo #(
      .WIDTH(data_bits),
      .DEPTH(fifo_deepth)
   ) u_rx_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (rx_wr),
      .wdata(rx_shift),
      .pop  (data_out_valid && data_out_ready),
      .rdata(data_out),
      .full (rx_full),
      .empty(rx_empty)
   );

   assign data_out_valid = !rx_empty;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: loopback frames, burst, backpressure,
// parity/framing errors, enables and mid-frame reset.
module tb_uart;

   localparam int SYS_CLK = 50_000_000;
   localparam int BAUD    = 3_000_000;
   localparam int DIV     = SYS_CLK / BAUD;
   localparam int FRAME   = 11;
   localparam int DEPTH   = 16;

   typedef logic [7:0] q8_t[$];
   typedef struct {
      logic [7:0]  word;
      logic [10:0] frame;
   } vec_t;

   logic       clk = 0;
   logic       rst_n = 0;
   logic       tx_en = 1;
   logic [7:0] data_in = '0;
   logic       data_in_valid = 0;
   logic       data_in_ready;
   logic       tx;
   logic       rx_en = 1;
   logic       rx;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready = 1;
   logic       check_flag;
   logic       ext_mode = 0;
   logic       rx_drv = 1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int flag_hi = 0;
   int flag_pulses = 0;
   logic flag_prev = 0;
   int push_cyc = 0;
   int first_cyc = -1;
   q8_t got;

   assign rx = ext_mode ? rx_drv : tx;

   uart #(
      .system_clk (SYS_CLK),
      .band_rate  (BAUD),
      .data_bits  (8),
      .check_mode (1),
      .stop_mode  (0),
      .fifo_deepth(DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tx_en         (tx_en),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .tx            (tx),
      .rx_en         (rx_en),
      .rx            (rx),
      .data_out      (data_out),
      .data_out_valid(data_out_valid),
      .data_out_ready(data_out_ready),
      .check_flag    (check_flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && data_out_valid && data_out_ready) begin
         if (got.size() == 0) first_cyc = cyc;
         got.push_back(data_out);
      end
      if (check_flag) flag_hi <= flag_hi + 1;
      if (check_flag && !flag_prev) flag_pulses <= flag_pulses + 1;
      flag_prev <= check_flag;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Odd parity: payload ones plus parity bit must be odd.
   function automatic logic odd_par(input logic [7:0] w);
      return ($countones(w) % 2) == 0;
   endfunction

   function automatic q8_t model_keep(input q8_t sent, input int cap);
      q8_t r;
      foreach (sent[i]) if (r.size() < cap) r.push_back(sent[i]);
      return r;
   endfunction

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 data_out_ready = v;
   endtask

   task automatic push(input logic [7:0] w);
      bit ok = 0;
      for (int i = 0; i < 40 * DIV && !ok; i++) begin
         @(negedge clk);
         if (data_in_ready) ok = 1;
      end
      if (!ok) chk("push_ready_timeout", 32'(ok), 1);
      push_cyc = cyc;
      data_in = w;
      data_in_valid = 1;
      @(negedge clk);
      data_in_valid = 0;
   endtask

   task automatic push_burst(input q8_t ws, output int stall_at);
      int n = 0;
      stall_at = -1;
      for (int c = 0; c < 40 * FRAME * DIV && n < ws.size(); c++) begin
         @(negedge clk);
         if (data_in_valid) n++;
         if (n < ws.size() && data_in_ready) begin
            data_in = ws[n];
            data_in_valid = 1;
         end else begin
            data_in_valid = 0;
            if (!data_in_ready && stall_at < 0 && n < ws.size())
               stall_at = n;
         end
      end
      data_in_valid = 0;
      chk("burst_all_pushed", 32'(n), 32'(ws.size()));
   endtask

   task automatic wait_got(input int n, input int bound);
      for (int i = 0; i < bound && got.size() < n; i++) @(negedge clk);
   endtask

   task automatic check_frame(input logic [7:0] w, input logic [10:0] f,
                              input string nm);
      bit seen = 0;
      int bad = 0;
      int f0 = flag_pulses;
      got.delete();
      push(w);
      for (int i = 0; i < 4 * DIV && !seen; i++) begin
         @(negedge clk);
         if (tx == 1'b0) seen = 1;
      end
      chk({nm, "_start_seen"}, 32'(seen), 1);
      for (int k = 0; k < FRAME * DIV; k++) begin
         if (tx !== f[k / DIV]) bad++;
         @(negedge clk);
      end
      chk({nm, "_tx_wave_errs"}, 32'(bad), 0);
      wait_got(1, 4 * DIV);
      chk({nm, "_rx_count"}, 32'(got.size()), 1);
      if (got.size() > 0) chk({nm, "_rx_word"}, 32'(got[0]), 32'(w));
      chk({nm, "_lat_ok"},
          32'((first_cyc - push_cyc >= 10 * DIV)
              && (first_cyc - push_cyc <= 11 * DIV + 6)), 1);
      chk({nm, "_no_flag"}, 32'(flag_pulses - f0), 0);
   endtask

   task automatic send_frame(input logic [7:0] w, input bit bad_par,
                             input logic stop_val);
      logic p;
      p = odd_par(w) ^ bad_par;
      ext_mode = 1;
      rx_drv = 0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = w[i];
         repeat (DIV) @(negedge clk);
      end
      rx_drv = p;
      repeat (DIV) @(negedge clk);
      rx_drv = stop_val;
      repeat (DIV) @(negedge clk);
      rx_drv = 1;
      repeat (2 * DIV) @(negedge clk);
      ext_mode = 0;
   endtask

   vec_t vecs[7];

   initial begin
      int stall;
      int bad;
      int f0;
      int h0;
      q8_t ws;
      q8_t exp_q;

      vecs[0] = '{8'h55, 11'b1_1_0101_0101_0};
      vecs[1] = '{8'h00, 11'b1_1_0000_0000_0};
      vecs[2] = '{8'hFF, 11'b1_1_1111_1111_0};
      vecs[3] = '{8'h01, 11'b1_0_0000_0001_0};
      vecs[4] = '{8'h80, 11'b1_0_1000_0000_0};
      vecs[5] = '{8'h3C, 11'b1_1_0011_1100_0};
      vecs[6] = '{8'hA7, 11'b1_0_1010_0111_0};

      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 1);
      chk("rst_in_ready", 32'(data_in_ready), 0);
      chk("rst_out_valid", 32'(data_out_valid), 0);
      chk("rst_data_out", 32'(data_out), 0);
      chk("rst_flag", 32'(check_flag), 0);
      rst_n = 1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(data_in_ready), 1);

      foreach (vecs[i]) check_frame(vecs[i].word, vecs[i].frame,
                                    $sformatf("vec%0d", i));

      got.delete();
      ws.delete();
      for (int i = 0; i < 20; i++) ws.push_back(8'(i));
      f0 = flag_pulses;
      push_burst(ws, stall);
      chk("burst_stall_at", 32'(stall), 17);
      wait_got(20, 22 * FRAME * DIV);
      chk("burst_rx_count", 32'(got.size()), 20);
      bad = 0;
      foreach (ws[i]) if (i >= got.size() || got[i] !== ws[i]) bad++;
      chk("burst_order_errs", 32'(bad), 0);
      chk("burst_no_flag", 32'(flag_pulses - f0), 0);

      set_ready(0);
      got.delete();
      ws.delete();
      for (int i = 0; i < 18; i++) ws.push_back(8'($urandom));
      push_burst(ws, stall);
      bad = 1;
      for (int i = 0; i < 4 * FRAME * DIV && bad; i++) begin
         @(negedge clk);
         if (data_out_valid) bad = 0;
      end
      chk("bp_first_valid", 32'(!bad), 1);
      bad = 0;
      repeat (19 * FRAME * DIV) begin
         @(negedge clk);
         if (!data_out_valid || data_out !== ws[0]) bad++;
      end
      chk("bp_head_stable_errs", 32'(bad), 0);
      set_ready(1);
      repeat (40) @(negedge clk);
      exp_q = model_keep(ws, DEPTH);
      chk("bp_rx_count", 32'(got.size()), 32'(exp_q.size()));
      bad = 0;
      foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) bad++;
      chk("bp_order_errs", 32'(bad), 0);
      chk("bp_drained", 32'(data_out_valid), 0);

      got.delete();
      f0 = flag_pulses;
      h0 = flag_hi;
      send_frame(8'hA5, 1, 1);
      wait_got(1, 4 * DIV);
      chk("a5_bad_par_flag", 32'(flag_pulses - f0), 1);
      chk("a5_flag_one_clk", 32'(flag_hi - h0), 1);
      if (got.size() > 0) chk("a5_bad_par_word", 32'(got[0]), 32'h A5);
      else chk("a5_bad_par_word", 32'(got.size()), 1);
      got.delete();
      f0 = flag_pulses;
      send_frame(8'hA5, 0, 1);
      wait_got(1, 4 * DIV);
      chk("a5_good_par_flag", 32'(flag_pulses - f0), 0);
      chk("a5_good_par_count", 32'(got.size()), 1);

      got.delete();
      exp_q.delete();
      f0 = flag_pulses;
      h0 = flag_hi;
      stall = 0;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] w;
         bit bp;
         logic sv;
         w = 8'($urandom);
         bp = ($urandom_range(0, 2) == 0);
         sv = ($urandom_range(0, 3) != 0);
         if (bp) stall++;
         if (sv) exp_q.push_back(w);
         send_frame(w, bp, sv);
      end
      repeat (4 * DIV) @(negedge clk);
      chk("rnd_ext_flags", 32'(flag_pulses - f0), 32'(stall));
      chk("rnd_ext_flag_width", 32'(flag_hi - h0), 32'(stall));
      chk("rnd_ext_count", 32'(got.size()), 32'(exp_q.size()));
      bad = 0;
      foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) bad++;
      chk("rnd_ext_order_errs", 32'(bad), 0);

      got.delete();
      ws.delete();
      f0 = flag_pulses;
      for (int i = 0; i < 10; i++) begin
         ws.push_back(8'($urandom));
         push(ws[i]);
         repeat ($urandom_range(0, 3 * DIV)) @(negedge clk);
      end
      wait_got(10, 12 * FRAME * DIV);
      chk("rnd_loop_count", 32'(got.size()), 10);
      bad = 0;
      foreach (ws[i]) if (i >= got.size() || got[i] !== ws[i]) bad++;
      chk("rnd_loop_order_errs", 32'(bad), 0);
      chk("rnd_loop_no_flag", 32'(flag_pulses - f0), 0);

      got.delete();
      rx_en = 0;
      push(8'h5A);
      bad = 0;
      repeat ((FRAME + 4) * DIV) begin
         @(negedge clk);
         if (data_out_valid) bad++;
      end
      chk("rxen_off_valid_cycles", 32'(bad), 0);
      rx_en = 1;

      tx_en = 0;
      push(8'h12);
      push(8'h34);
      bad = 0;
      repeat (3 * FRAME * DIV) begin
         @(negedge clk);
         if (!tx) bad++;
      end
      chk("txen_off_low_cycles", 32'(bad), 0);
      tx_en = 1;
      wait_got(2, 4 * FRAME * DIV);
      chk("txen_resume_count", 32'(got.size()), 2);
      if (got.size() == 2)
         chk("txen_resume_words", 32'({got[0], got[1]}), 32'h1234);

      set_ready(0);
      got.delete();
      push(8'h11);
      bad = 1;
      for (int i = 0; i < 2 * FRAME * DIV && bad; i++) begin
         @(negedge clk);
         if (data_out_valid) bad = 0;
      end
      chk("rst_pre_valid", 32'(!bad), 1);
      push(8'h22);
      repeat (5 * DIV) @(negedge clk);
      chk("rst_pre_tx_busy", 32'(tx), 0);
      rst_n = 0;
      #1;
      chk("midrst_tx", 32'(tx), 1);
      chk("midrst_out_valid", 32'(data_out_valid), 0);
      chk("midrst_in_ready", 32'(data_in_ready), 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      set_ready(1);
      check_frame(8'h3C, 11'b1_1_0011_1100_0, "post_rst");
      got.delete();
      repeat (2 * FRAME * DIV) @(negedge clk);
      chk("post_rst_no_stale", 32'(got.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
